// File: rtl/bow_draw_ctrl.sv
// Bow charge/release controller: converts the fire button into a bow animation frame,
// steps the frame only at vsync, and emits a one-cycle arrow launch pulse carrying the charge power.
module bow_draw_ctrl #(
    parameter int NUM_FRAMES     = 6,
    parameter int TICKS_PER_STEP = 4,
    parameter int COOLDOWN_TICKS = 15
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vs,
    input  logic       fire_btn,
    input  logic       game_active,
    output logic [2:0] bow_frame,
    output logic       arrow_fire,
    output logic [2:0] arrow_power,
    output logic [7:0] arrows_fired,
    output logic       drawing
);
    localparam int STEP_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam int COOL_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam logic [2:0]        MAX_LEVEL = 3'(NUM_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TICKS_PER_STEP - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_TICKS - 1);

    typedef enum logic [2:0] {IDLE, DRAW, FULL, RELEASE, COOLDOWN} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        draw_level_reg, draw_level_next;
    logic [STEP_W-1:0] step_cnt_reg, step_cnt_next;
    logic [COOL_W-1:0] cool_cnt_reg, cool_cnt_next;
    logic              btn_meta_reg, btn_s_reg, btn_d_reg;
    logic [1:0]        sync_fill_reg;
    logic              btn_armed_reg;
    logic              vs_d_reg;
    logic              press, release_evt, tick;
    logic              fire_next, drawing_next;

    // A press only counts once the synchronizer has seen the button low after reset,
    // so a button held through reset cannot start a draw.
    assign press       = btn_s_reg & ~btn_d_reg & btn_armed_reg;
    assign release_evt = ~btn_s_reg & btn_d_reg;
    assign tick        = vs_d_reg & ~vs;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_reg  <= 1'b0;
            btn_s_reg     <= 1'b0;
            btn_d_reg     <= 1'b0;
            sync_fill_reg <= 2'b00;
            btn_armed_reg <= 1'b0;
            vs_d_reg      <= 1'b0;
        end else begin
            btn_meta_reg  <= fire_btn;
            btn_s_reg     <= btn_meta_reg;
            btn_d_reg     <= btn_s_reg;
            sync_fill_reg <= {sync_fill_reg[0], 1'b1};
            if (sync_fill_reg[1] && !btn_s_reg)
                btn_armed_reg <= 1'b1;
            vs_d_reg      <= vs;
        end
    end

    always_comb begin
        state_next      = state_reg;
        draw_level_next = draw_level_reg;
        step_cnt_next   = step_cnt_reg;
        cool_cnt_next   = cool_cnt_reg;
        if (!game_active) begin
            state_next      = IDLE;
            draw_level_next = 3'd0;
            step_cnt_next   = '0;
            cool_cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    draw_level_next = 3'd0;
                    if (press) begin
                        state_next    = DRAW;
                        step_cnt_next = '0;
                    end
                end
                DRAW, FULL: begin
                    // Release takes priority over a coincident tick: power is the pre-tick level.
                    if (release_evt) begin
                        state_next = (draw_level_reg != 3'd0) ? RELEASE : IDLE;
                    end else if (state_reg == DRAW && tick) begin
                        if (step_cnt_reg == STEP_LAST) begin
                            step_cnt_next   = '0;
                            draw_level_next = draw_level_reg + 3'd1;
                            if (draw_level_reg + 3'd1 == MAX_LEVEL)
                                state_next = FULL;
                        end else begin
                            step_cnt_next = step_cnt_reg + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state_next    = COOLDOWN;
                    cool_cnt_next = '0;
                end
                COOLDOWN: begin
                    if (tick) begin
                        if (cool_cnt_reg == COOL_LAST) begin
                            state_next      = IDLE;
                            cool_cnt_next   = '0;
                            draw_level_next = 3'd0;
                        end else begin
                            cool_cnt_next = cool_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next      = IDLE;
                    draw_level_next = 3'd0;
                end
            endcase
        end
    end

    assign fire_next    = (state_reg == RELEASE) && game_active;
    assign drawing_next = (state_next == DRAW) || (state_next == FULL);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            draw_level_reg <= 3'd0;
            step_cnt_reg   <= '0;
            cool_cnt_reg   <= '0;
            bow_frame      <= 3'd0;
            arrow_fire     <= 1'b0;
            arrow_power    <= 3'd0;
            arrows_fired   <= 8'd0;
            drawing        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            draw_level_reg <= draw_level_next;
            step_cnt_reg   <= step_cnt_next;
            cool_cnt_reg   <= cool_cnt_next;
            // Frame only changes at vsync so the sprite never tears mid-scan.
            if (tick)
                bow_frame <= drawing_next ? draw_level_next : 3'd0;
            arrow_fire     <= fire_next;
            arrow_power    <= fire_next ? draw_level_reg : 3'd0;
            arrows_fired   <= arrows_fired + {7'd0, fire_next};
            drawing        <= drawing_next;
        end
    end
endmodule

// File: tb/tb_bow_draw_ctrl.sv
// Self-checking bench for bow_draw_ctrl: directed scenarios plus randomized holds
// checked against a tick-counting power model.
module tb_bow_draw_ctrl;
    localparam int NF  = 6;
    localparam int TPS = 2;
    localparam int CT  = 3;

    logic       vga_clk     = 1'b0;
    logic       reset_n     = 1'b0;
    logic       vs          = 1'b1;
    logic       fire_btn    = 1'b0;
    logic       game_active = 1'b1;
    logic [2:0] bow_frame;
    logic       arrow_fire;
    logic [2:0] arrow_power;
    logic [7:0] arrows_fired;
    logic       drawing;

    int   tests     = 0;
    int   fails     = 0;
    int   cyc       = 0;
    int   exp_fired = 0;
    int   tick_edges[$];
    event tick_ev;

    bow_draw_ctrl #(.NUM_FRAMES(NF), .TICKS_PER_STEP(TPS), .COOLDOWN_TICKS(CT)) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs), .fire_btn(fire_btn),
        .game_active(game_active), .bow_frame(bow_frame), .arrow_fire(arrow_fire),
        .arrow_power(arrow_power), .arrows_fired(arrows_fired), .drawing(drawing)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc <= cyc + 1;

    // vsync: low for one cycle every 20 clocks; record the edge at which the DUT sees each tick
    initial begin
        forever begin
            repeat (19) @(posedge vga_clk);
            #1 vs = 1'b0;
            @(posedge vga_clk);
            #1 vs = 1'b1;
            tick_edges.push_back(cyc);
            -> tick_ev;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Button edge reaches the state 3 edges after it is driven; count ticks strictly
    // between press-processing and release-processing edges, one level per TPS ticks.
    function automatic int model_power(input int e, input int r);
        int n = 0;
        foreach (tick_edges[i])
            if (tick_edges[i] > e + 3 && tick_edges[i] < r + 3) n++;
        n = n / TPS;
        if (n > NF - 1) n = NF - 1;
        return n;
    endfunction

    task automatic watch_launch(input int ncyc, output int pulses, output int pw, output int stray);
        pulses = 0; pw = 0; stray = 0;
        repeat (ncyc) begin
            @(posedge vga_clk);
            #2;
            if (arrow_fire === 1'b1) begin
                pulses++;
                pw = int'(arrow_power);
            end else if (arrow_power !== 3'd0) begin
                stray++;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge vga_clk);
        #1;
        tests++;
        if ({bow_frame, arrow_fire, arrow_power, arrows_fired, drawing} !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: got frame=%0d fire=%0b power=%0d fired=%0d drawing=%0b, required all 0",
                     bow_frame, arrow_fire, arrow_power, arrows_fired, drawing);
        end
        reset_n = 1'b1;
        exp_fired = 0;
        repeat (2) @(tick_ev);
        $display("[TB] reset: outputs zero checked");
    endtask

    task automatic test_full_draw;
        int e, r, p, pw, st, exp_frame;
        @(tick_ev);
        fire_btn = 1'b1;
        e = cyc;
        for (int k = 1; k <= 12; k++) begin
            @(tick_ev);
            #1;
            exp_frame = (k / TPS > NF - 1) ? NF - 1 : k / TPS;
            tests++;
            if (bow_frame !== 3'(exp_frame) || drawing !== 1'b1) begin
                fails++;
                $display("FAIL full_draw_tick%0d: got frame=%0d drawing=%0b, required frame=%0d drawing=1",
                         k, bow_frame, drawing, exp_frame);
            end
            if (k < 12) begin
                repeat (10) @(posedge vga_clk);
                #1;
                tests++;
                if (bow_frame !== 3'(exp_frame)) begin
                    fails++;
                    $display("FAIL full_draw_hold%0d: got frame=%0d between ticks, required %0d",
                             k, bow_frame, exp_frame);
                end
            end
        end
        fire_btn = 1'b0;
        r = cyc;
        watch_launch(10, p, pw, st);
        exp_fired++;
        tests++;
        if (p !== 1 || pw !== model_power(e, r) || pw !== NF - 1 || st !== 0 || arrows_fired !== 8'(exp_fired)) begin
            fails++;
            $display("FAIL full_draw_launch: got pulses=%0d power=%0d stray=%0d fired=%0d, required 1/%0d/0/%0d",
                     p, pw, st, arrows_fired, NF - 1, exp_fired);
        end
        $display("[TB] full draw: launch power=%0d fired=%0d", pw, arrows_fired);
        repeat (CT + 1) @(tick_ev);
    endtask

    task automatic test_short_hold_cooldown;
        int e, r, p, pw, st;
        @(tick_ev);
        fire_btn = 1'b1;
        e = cyc;
        repeat (3) @(tick_ev);
        fire_btn = 1'b0;
        r = cyc;
        watch_launch(10, p, pw, st);
        exp_fired++;
        tests++;
        if (p !== 1 || pw !== 1 || pw !== model_power(e, r) || arrows_fired !== 8'(exp_fired)) begin
            fails++;
            $display("FAIL short_hold_launch: got pulses=%0d power=%0d fired=%0d, required 1/1/%0d",
                     p, pw, arrows_fired, exp_fired);
        end
        @(tick_ev);
        #1;
        tests++;
        if (bow_frame !== 3'd0) begin
            fails++;
            $display("FAIL short_hold_frame: got frame=%0d after release tick, required 0", bow_frame);
        end
        repeat (5) @(posedge vga_clk);
        #1 fire_btn = 1'b1;
        repeat (5) @(posedge vga_clk);
        #1;
        tests++;
        if (drawing !== 1'b0) begin
            fails++;
            $display("FAIL cooldown_ignore1: got drawing=%0b, required 0", drawing);
        end
        fire_btn = 1'b0;
        @(tick_ev);
        repeat (3) @(posedge vga_clk);
        #1 fire_btn = 1'b1;
        repeat (6) @(posedge vga_clk);
        #1;
        tests++;
        if (drawing !== 1'b0) begin
            fails++;
            $display("FAIL cooldown_ignore2: got drawing=%0b, required 0", drawing);
        end
        fire_btn = 1'b0;
        @(tick_ev);
        repeat (2) @(posedge vga_clk);
        #1 fire_btn = 1'b1;
        repeat (4) @(posedge vga_clk);
        #1;
        tests++;
        if (drawing !== 1'b1) begin
            fails++;
            $display("FAIL cooldown_over_press: got drawing=%0b, required 1", drawing);
        end
        fire_btn = 1'b0;
        repeat (6) @(posedge vga_clk);
        #1;
        tests++;
        if (drawing !== 1'b0 || arrows_fired !== 8'(exp_fired)) begin
            fails++;
            $display("FAIL cooldown_tap_back: got drawing=%0b fired=%0d, required 0/%0d",
                     drawing, arrows_fired, exp_fired);
        end
        $display("[TB] short hold + cooldown: power=%0d", pw);
        @(tick_ev);
    endtask

    task automatic test_tap;
        int p, pw, st;
        @(tick_ev);
        fire_btn = 1'b1;
        @(tick_ev);
        repeat (5) @(posedge vga_clk);
        #1 fire_btn = 1'b0;
        watch_launch(10, p, pw, st);
        tests++;
        if (p !== 0 || st !== 0 || arrows_fired !== 8'(exp_fired) || drawing !== 1'b0) begin
            fails++;
            $display("FAIL tap: got pulses=%0d stray=%0d fired=%0d drawing=%0b, required 0/0/%0d/0",
                     p, st, arrows_fired, drawing, exp_fired);
        end
        $display("[TB] tap: pulses=%0d fired=%0d", p, arrows_fired);
    endtask

    task automatic test_release_on_tick;
        int e, r, p, pw, st;
        @(tick_ev);
        fire_btn = 1'b1;
        e = cyc;
        repeat (5) @(tick_ev);
        repeat (17) @(posedge vga_clk);
        #1 fire_btn = 1'b0;
        r = cyc;
        watch_launch(10, p, pw, st);
        exp_fired++;
        tests++;
        if (p !== 1 || pw !== 2 || pw !== model_power(e, r) || arrows_fired !== 8'(exp_fired)) begin
            fails++;
            $display("FAIL release_on_tick: got pulses=%0d power=%0d fired=%0d, required 1/2/%0d",
                     p, pw, arrows_fired, exp_fired);
        end
        $display("[TB] release on tick: power=%0d", pw);
        repeat (CT + 1) @(tick_ev);
    endtask

    task automatic test_game_active_drop;
        int p, pw, st;
        @(tick_ev);
        fire_btn = 1'b1;
        repeat (11) @(tick_ev);
        fire_btn = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1 game_active = 1'b0;
        @(posedge vga_clk);
        #1 game_active = 1'b1;
        watch_launch(8, p, pw, st);
        tests++;
        if (p !== 0 || st !== 0 || arrows_fired !== 8'(exp_fired)) begin
            fails++;
            $display("FAIL game_drop_launch: got pulses=%0d stray=%0d fired=%0d, required 0/0/%0d",
                     p, st, arrows_fired, exp_fired);
        end
        @(tick_ev);
        #1;
        tests++;
        if (bow_frame !== 3'd0 || drawing !== 1'b0) begin
            fails++;
            $display("FAIL game_drop_frame: got frame=%0d drawing=%0b, required 0/0", bow_frame, drawing);
        end
        $display("[TB] game_active drop: pulses=%0d frame=%0d", p, bow_frame);
    endtask

    task automatic test_random_holds;
        int e, r, p, pw, st, pw_exp;
        for (int i = 0; i < 20; i++) begin
            @(tick_ev);
            repeat ($urandom_range(0, 19)) @(posedge vga_clk);
            #1 fire_btn = 1'b1;
            e = cyc;
            repeat ($urandom_range(5, 260)) @(posedge vga_clk);
            #1 fire_btn = 1'b0;
            r = cyc;
            watch_launch(10, p, pw, st);
            pw_exp = model_power(e, r);
            if (pw_exp > 0) exp_fired++;
            tests++;
            if (p !== ((pw_exp > 0) ? 1 : 0) || pw !== pw_exp || st !== 0 || arrows_fired !== 8'(exp_fired)) begin
                fails++;
                $display("FAIL random_hold%0d: got pulses=%0d power=%0d stray=%0d fired=%0d, required power=%0d fired=%0d",
                         i, p, pw, st, arrows_fired, pw_exp, exp_fired);
            end
            $display("[TB] random hold %0d: cycles=%0d power=%0d fired=%0d", i, r - e, pw, arrows_fired);
            repeat (CT + 1) @(tick_ev);
        end
    endtask

    task automatic test_reset_mid_draw;
        @(tick_ev);
        fire_btn = 1'b1;
        repeat (3) @(tick_ev);
        #1;
        tests++;
        if (bow_frame !== 3'd1 || drawing !== 1'b1) begin
            fails++;
            $display("FAIL mid_draw_pre: got frame=%0d drawing=%0b, required 1/1", bow_frame, drawing);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({bow_frame, arrow_fire, arrow_power, arrows_fired, drawing} !== 16'd0) begin
            fails++;
            $display("FAIL mid_draw_async_reset: got frame=%0d fire=%0b power=%0d fired=%0d drawing=%0b, required all 0",
                     bow_frame, arrow_fire, arrow_power, arrows_fired, drawing);
        end
        @(posedge vga_clk);
        #1 reset_n = 1'b1;
        exp_fired = 0;
        for (int k = 0; k < 3; k++) begin
            @(tick_ev);
            #1;
            tests++;
            if (drawing !== 1'b0 || bow_frame !== 3'd0) begin
                fails++;
                $display("FAIL held_after_reset%0d: got drawing=%0b frame=%0d, required 0/0", k, drawing, bow_frame);
            end
        end
        fire_btn = 1'b0;
        repeat (5) @(posedge vga_clk);
        #1 fire_btn = 1'b1;
        repeat (4) @(posedge vga_clk);
        #1;
        tests++;
        if (drawing !== 1'b1) begin
            fails++;
            $display("FAIL repress_after_reset: got drawing=%0b, required 1", drawing);
        end
        fire_btn = 1'b0;
        repeat (6) @(posedge vga_clk);
        $display("[TB] reset mid-draw: fresh press required");
    endtask

    task automatic test_wrap;
        int p, pw, st;
        while (exp_fired < 256) begin
            @(tick_ev);
            fire_btn = 1'b1;
            repeat (2) @(tick_ev);
            #1 fire_btn = 1'b0;
            watch_launch(10, p, pw, st);
            exp_fired++;
            tests++;
            if (p !== 1 || pw !== 1 || arrows_fired !== 8'(exp_fired)) begin
                fails++;
                $display("FAIL wrap_launch%0d: got pulses=%0d power=%0d fired=%0d, required 1/1/%0d",
                         exp_fired, p, pw, arrows_fired, exp_fired % 256);
            end
            repeat (CT) @(tick_ev);
        end
        tests++;
        if (arrows_fired !== 8'd0) begin
            fails++;
            $display("FAIL wrap_final: got fired=%0d after 256 launches, required 0", arrows_fired);
        end
        $display("[TB] wrap: 256 launches, fired=%0d", arrows_fired);
    endtask

    initial begin
        test_reset;
        test_full_draw;
        test_short_hold_cooldown;
        test_tap;
        test_release_on_tick;
        test_game_active_drop;
        test_random_holds;
        test_reset_mid_draw;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
